// File: rtl/sc_stream_decoder.sv
// -----------------------------------------------------------------------------
// sc_stream_decoder
//
// Stochastic-to-binary converter. Counts the 1s of a unipolar stochastic
// bitstream over a window of 'len' accepted bits and reports the count once
// the window closes. This is the receiving end of the LFSR-driven
// binary-to-stochastic generators. The result feeds accuracy/error logging.
//
// Parameters:
//   LW      width of the window length and of the ones count; the largest
//           window is 2^LW-1 bits.
//
// Ports:
//   clk     clock
//   rst     synchronous, active-high reset
//   start   begin a new window; only honoured while idle
//   len     window length in accepted bits, latched when start is honoured
//   bit_in  stochastic bitstream bit
//   bit_en  bit_in is valid this cycle; low stalls the window
//   ones    count of 1s in the last completed window, held until the next
//           completion
//   done    one-cycle pulse; ones is updated in this same cycle
//   busy    high while a window is being accumulated
// -----------------------------------------------------------------------------
module sc_stream_decoder #(
    parameter int unsigned LW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic          bit_in,
    input  logic          bit_en,
    output logic [LW-1:0] ones,
    output logic          done,
    output logic          busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    state_e        state_q;
    logic [LW-1:0] remaining_q;  // accepted bits still to come in this window
    logic [LW-1:0] acc_q;        // running count of 1s in the open window
    logic [LW-1:0] ones_q;
    logic          done_q;
    logic          busy_q;

    // bit_in widened to the accumulator width so the add is width-matched.
    logic [LW-1:0] bit_ext;
    assign bit_ext = {{(LW-1){1'b0}}, bit_in};

    // acc never exceeds the number of bits already accepted, and that never
    // exceeds len <= 2^LW-1, so the sum below cannot wrap.
    logic [LW-1:0] acc_plus_bit;
    assign acc_plus_bit = acc_q + bit_ext;

    // NOTE: all state lives in one clocked block and is assigned with <= so
    // every register samples the pre-edge values of the others; blocking
    // assignments here would let later statements see already-updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset aborts any open window without producing a done pulse.
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            acc_q       <= '0;
            ones_q      <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // done is a pulse: it falls back unless a window closes now.
            done_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    // bit_in/bit_en in the start cycle are deliberately ignored.
                    if (start) begin
                        if (len != '0) begin
                            remaining_q <= len;
                            acc_q       <= '0;
                            state_q     <= ST_ACCUM;
                            busy_q      <= 1'b1;
                        end else begin
                            // Empty window completes immediately with zero.
                            ones_q <= '0;
                            done_q <= 1'b1;
                        end
                    end
                end

                ST_ACCUM: begin
                    // start and len are not looked at here; a new window can
                    // only open once this one has completed.
                    if (bit_en) begin
                        if (remaining_q == LW'(1)) begin
                            ones_q      <= acc_plus_bit;
                            done_q      <= 1'b1;
                            acc_q       <= '0;
                            remaining_q <= '0;
                            state_q     <= ST_IDLE;
                            busy_q      <= 1'b0;
                        end else begin
                            acc_q       <= acc_plus_bit;
                            remaining_q <= remaining_q - LW'(1);
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ones = ones_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// -----------------------------------------------------------------------------
// tb_sc_stream_decoder
//
// Directed bench for sc_stream_decoder. Inputs change 1 time unit after each
// rising edge and outputs are observed at the same point, so every check sees
// the state produced by the edge just passed. Edge 0 is the edge that accepts
// start; with no stalls the last bit is sampled at edge len and done is
// observed right after it.
// -----------------------------------------------------------------------------
module tb_sc_stream_decoder;

    localparam int unsigned LW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic          bit_in;
    logic          bit_en;
    logic [LW-1:0] ones;
    logic          done;
    logic          busy;

    int checks;
    int failures;

    sc_stream_decoder #(.LW(LW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .len    (len),
        .bit_in (bit_in),
        .bit_en (bit_en),
        .ones   (ones),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        logic [7:0] pat;
        int         early_done;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        bit_in   = 1'b0;
        bit_en   = 1'b0;

        // ---- reset, then idle ------------------------------------------------
        tick();
        tick();
        check("rst_ones", 32'(ones), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("idle_ones", 32'(ones), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end

        // ---- len=16, all ones, no stalls ------------------------------------
        // bit_en/bit_in already high in the start cycle: that bit is ignored.
        start  = 1'b1;
        len    = 16'd16;
        bit_in = 1'b1;
        bit_en = 1'b1;
        tick();                                   // edge 0
        start = 1'b0;
        len   = 16'd3;                            // must not be re-sampled
        check("w16_busy_start", 32'(busy), 32'd1);
        check("w16_done_start", 32'(done), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k < 16) begin
                check("w16_busy_mid", 32'(busy), 32'd1);
                check("w16_done_mid", 32'(done), 32'd0);
                check("w16_ones_mid", 32'(ones), 32'd0);
            end
        end
        check("w16_done", 32'(done), 32'd1);
        check("w16_ones", 32'(ones), 32'd16);
        check("w16_busy_end", 32'(busy), 32'd0);
        bit_en = 1'b0;
        tick();
        check("w16_done_pulse", 32'(done), 32'd0);
        check("w16_ones_held", 32'(ones), 32'd16);

        // ---- len=8, pattern 1,0,1,1,0,0,1,0 with a stall after each bit ------
        pat   = 8'b1011_0010;
        start = 1'b1;
        len   = 16'd8;
        tick();                                   // edge 0
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bit_in = pat[7-i];
            bit_en = 1'b1;
            tick();                               // edge 2*i+1
            if (i < 7) begin
                check("w8_done_bit", 32'(done), 32'd0);
                check("w8_ones_stable", 32'(ones), 32'd16);
                bit_en = 1'b0;
                bit_in = 1'b1;                    // garbage while stalled
                tick();
                check("w8_done_stall", 32'(done), 32'd0);
                check("w8_busy_stall", 32'(busy), 32'd1);
            end
        end
        check("w8_done", 32'(done), 32'd1);
        check("w8_ones", 32'(ones), 32'd4);
        check("w8_busy_end", 32'(busy), 32'd0);
        bit_en = 1'b0;
        tick();
        check("w8_done_pulse", 32'(done), 32'd0);

        // ---- len=0: immediate completion ------------------------------------
        start = 1'b1;
        len   = 16'd0;
        tick();
        start = 1'b0;
        check("w0_done", 32'(done), 32'd1);
        check("w0_ones", 32'(ones), 32'd0);
        check("w0_busy", 32'(busy), 32'd0);
        tick();
        check("w0_done_pulse", 32'(done), 32'd0);
        check("w0_busy_after", 32'(busy), 32'd0);

        // ---- back-to-back: len=4 of 1s, then len=4 of 0s from the done cycle -
        start  = 1'b1;
        len    = 16'd4;
        bit_in = 1'b1;
        bit_en = 1'b1;
        tick();                                   // edge 0
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 2) begin
                start = 1'b1;                     // ignored: window in progress
                len   = 16'd2;
            end else begin
                start = 1'b0;
            end
            tick();
            if (k < 4) begin
                check("bb1_done_mid", 32'(done), 32'd0);
                check("bb1_busy_mid", 32'(busy), 32'd1);
            end
        end
        check("bb1_done", 32'(done), 32'd1);
        check("bb1_ones", 32'(ones), 32'd4);
        start  = 1'b1;                            // asserted in the done cycle
        len    = 16'd4;
        bit_in = 1'b0;
        tick();
        start = 1'b0;
        check("bb2_accept_busy", 32'(busy), 32'd1);
        check("bb2_accept_done", 32'(done), 32'd0);
        check("bb2_ones_held", 32'(ones), 32'd4);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) check("bb2_done_mid", 32'(done), 32'd0);
        end
        check("bb2_done", 32'(done), 32'd1);
        check("bb2_ones", 32'(ones), 32'd0);
        bit_en = 1'b0;
        tick();
        check("bb2_done_pulse", 32'(done), 32'd0);

        // ---- len=10 aborted by rst after 5 ones; rst beats start -------------
        start  = 1'b1;
        len    = 16'd10;
        bit_in = 1'b1;
        bit_en = 1'b1;
        tick();                                   // edge 0
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("abort_busy_pre", 32'(busy), 32'd1);
        rst   = 1'b1;
        start = 1'b1;                             // rst has priority
        len   = 16'd2;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("abort_ones", 32'(ones), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_idle", 32'(busy), 32'd0);
        end

        // ---- len=65535 of all 1s: full-scale count, no wrap ------------------
        start  = 1'b1;
        len    = 16'hFFFF;
        bit_in = 1'b1;
        bit_en = 1'b1;
        tick();                                   // edge 0
        start      = 1'b0;
        early_done = 0;
        for (int k = 1; k < 65535; k++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b1) early_done++;
        end
        check("max_no_early_done", 32'(early_done), 32'd0);
        tick();                                   // edge 65535
        check("max_done", 32'(done), 32'd1);
        check("max_ones", 32'(ones), 32'd65535);
        check("max_busy_end", 32'(busy), 32'd0);
        bit_en = 1'b0;
        tick();
        check("max_done_pulse", 32'(done), 32'd0);
        check("max_ones_held", 32'(ones), 32'd65535);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
